usb_tx_scheduler: RTL and testbench

Sequencing controller in front of usb_transmitter, clocked at 96 MHz (8 clocks per 12 Mb/s bit).
- Accepts ACK, NAK and DATA send requests from the protocol FSM.
- Arbitrates between pending requests.
- For DATA: streams payload bytes from the SD-side show-ahead FIFO into the transmitter buffer (write_enable/buffer_data), then issues write_done.
- Pulses tx_ena with the matching type strobe, waits for tx_done, then enforces an inter-packet gap.
- Watchdog aborts stalled loads or transmissions.

---
 rtl/usb_tx_pkg.sv | 16 +
 rtl/tx_watchdog.sv | 28 ++
 rtl/usb_tx_scheduler.sv | 153 +++++++++++++++
 tb/tb_usb_tx_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit scheduler.
package usb_tx_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, LDONE, ISSUE, WAIT_TX, GAP} state_t;

  typedef enum logic [1:0] {PK_ACK, PK_NAK, PK_DATA} pkt_kind_t;

  localparam int MAX_LEN_DEFAULT = 64;
  localparam int CLKS_PER_BIT    = 8;
  localparam int WD_WIDTH        = 14;

  function automatic logic [6:0] clamp_len(input logic [6:0] len, input logic [6:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/tx_watchdog.sv
// Clearable up-counter with enable; tc is high while enabled and the count equals limit.
module tx_watchdog #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Holds at the limit so a late state change never wraps the count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = enable && (count == limit);

endmodule

// File: rtl/usb_tx_scheduler.sv
// Sequences ACK/NAK/DATA packets into usb_transmitter: buffer load, start strobe,
// completion wait, inter-packet gap and a stall watchdog.
module usb_tx_scheduler
  import usb_tx_pkg::*;
#(
  parameter int MAX_LEN        = MAX_LEN_DEFAULT,
  parameter int TIMEOUT_CYCLES = 12000,
  parameter int IPG_CYCLES     = 2 * CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       req_ack,
  input  logic       req_nack,
  input  logic       req_data,
  input  logic [6:0] data_len,
  input  logic [7:0] fifo_rdata,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  input  logic       tx_done,
  output logic       tx_ena,
  output logic       send_data,
  output logic       tx_ack,
  output logic       tx_nack,
  output logic [7:0] buffer_data,
  output logic       write_enable,
  output logic       write_done,
  output logic       busy,
  output logic       sent,
  output logic       err_timeout
);

  localparam logic [6:0]          MAX_LEN_L = 7'(MAX_LEN);
  localparam logic [WD_WIDTH-1:0] WD_LIMIT  = WD_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WD_WIDTH-1:0] IPG_LIMIT = WD_WIDTH'(IPG_CYCLES - 1);

  state_t    state, state_next;
  pkt_kind_t kind, kind_next;
  logic      pend_ack, pend_nack, pend_data;
  logic [6:0] pend_len, byte_cnt, load_len;
  logic      take_ack, take_nack, take_data, pop;
  logic      wd_tc, ipg_tc;

  assign load_len = clamp_len(pend_len, MAX_LEN_L);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // The first DATA byte is popped in the dispatching IDLE cycle so the load
  // starts as early as possible.
  always_comb begin
    state_next = state;
    kind_next  = kind;
    take_ack   = 1'b0;
    take_nack  = 1'b0;
    take_data  = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (pend_ack) begin
          take_ack   = 1'b1;
          kind_next  = PK_ACK;
          state_next = ISSUE;
        end else if (pend_nack) begin
          take_nack  = 1'b1;
          kind_next  = PK_NAK;
          state_next = ISSUE;
        end else if (pend_data) begin
          take_data = 1'b1;
          kind_next = PK_DATA;
          if (load_len == 7'd0) begin
            state_next = LDONE;
          end else begin
            pop        = !fifo_empty;
            state_next = (pop && load_len == 7'd1) ? LDONE : LOAD;
          end
        end
      end
      LOAD: begin
        if (wd_tc) begin
          state_next = GAP;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          if (byte_cnt == 7'd1) state_next = LDONE;
        end
      end
      LDONE:   if (!write_enable) state_next = ISSUE;
      ISSUE:   state_next = WAIT_TX;
      WAIT_TX: if (tx_done || wd_tc) state_next = GAP;
      GAP:     if (ipg_tc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A new request in the same cycle as a dispatch re-arms the flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend_ack     <= 1'b0;
      pend_nack    <= 1'b0;
      pend_data    <= 1'b0;
      pend_len     <= '0;
      byte_cnt     <= '0;
      kind         <= PK_ACK;
      buffer_data  <= '0;
      write_enable <= 1'b0;
      write_done   <= 1'b0;
      tx_ena       <= 1'b0;
      send_data    <= 1'b0;
      tx_ack       <= 1'b0;
      tx_nack      <= 1'b0;
    end else begin
      pend_ack  <= req_ack  || (pend_ack  && !take_ack);
      pend_nack <= req_nack || (pend_nack && !(take_ack || take_nack));
      pend_data <= req_data || (pend_data && !take_data);
      if (req_data && (!pend_data || take_data)) pend_len <= data_len;
      kind <= kind_next;
      if (take_data)  byte_cnt <= load_len - {6'd0, pop};
      else if (pop)   byte_cnt <= byte_cnt - 7'd1;
      write_enable <= pop;
      if (pop) buffer_data <= fifo_rdata;
      write_done <= (state_next == LDONE) && !pop;
      tx_ena     <= (state_next == ISSUE);
      send_data  <= (state_next == ISSUE) && (kind_next == PK_DATA);
      tx_ack     <= (state_next == ISSUE) && (kind_next == PK_ACK);
      tx_nack    <= (state_next == ISSUE) && (kind_next == PK_NAK);
    end
  end

  tx_watchdog #(.WIDTH(WD_WIDTH)) u_watchdog (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  ((state_next == LOAD || state_next == WAIT_TX) && state_next != state),
    .enable (state == LOAD || state == WAIT_TX),
    .limit  (WD_LIMIT),
    .tc     (wd_tc)
  );

  tx_watchdog #(.WIDTH(WD_WIDTH)) u_ipg (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (state_next == GAP && state != GAP),
    .enable (state == GAP),
    .limit  (IPG_LIMIT),
    .tc     (ipg_tc)
  );

  assign fifo_rd     = pop;
  assign busy        = (state != IDLE);
  assign sent        = (state == WAIT_TX) && tx_done;
  assign err_timeout = wd_tc && !sent;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Scoreboard bench for usb_tx_scheduler: bytes and event cycles are recorded per
// cycle and compared against values the bench computes itself.
module tb_usb_tx_scheduler;

  logic       clk = 1'b0, n_rst = 1'b0;
  logic       req_ack = 1'b0, req_nack = 1'b0, req_data = 1'b0, tx_done = 1'b0;
  logic [6:0] data_len = '0;
  logic [7:0] fifo_rdata;
  logic       fifo_empty, fifo_rd;
  logic       tx_ena, send_data, tx_ack, tx_nack, write_enable, write_done;
  logic       busy, sent, err_timeout;
  logic [7:0] buffer_data;

  usb_tx_scheduler dut (
    .clk(clk), .n_rst(n_rst), .req_ack(req_ack), .req_nack(req_nack),
    .req_data(req_data), .data_len(data_len), .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .tx_done(tx_done),
    .tx_ena(tx_ena), .send_data(send_data), .tx_ack(tx_ack), .tx_nack(tx_nack),
    .buffer_data(buffer_data), .write_enable(write_enable), .write_done(write_done),
    .busy(busy), .sent(sent), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model
  logic [7:0] fifo_mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_rdata = fifo_mem[rd_ptr];
  always @(posedge clk) if (fifo_rd) rd_ptr <= rd_ptr + 8'd1;

  int checks = 0, passes = 0, cyc = 0, t0 = 0, done_delay = 0, tx_done_at = -1;
  logic prev_busy = 1'b0;
  int we_cyc_q[$], wd_cyc_q[$], tx_cyc_q[$], sent_cyc_q[$], err_cyc_q[$], busy_fall_q[$];
  logic [7:0] got_q[$], exp_q[$];
  logic [2:0] kind_q[$];

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  function automatic int kind_first(input logic [2:0] q[$]);
    return (q.size() > 0) ? int'(q[0]) : -1;
  endfunction

  task automatic push_byte(input logic [7:0] b, input bit expect_it);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
    if (expect_it) exp_q.push_back(b);
  endtask

  task automatic clear_obs();
    we_cyc_q.delete(); wd_cyc_q.delete(); tx_cyc_q.delete(); sent_cyc_q.delete();
    err_cyc_q.delete(); busy_fall_q.delete(); got_q.delete(); kind_q.delete();
    exp_q.delete();
    tx_done_at = -1;
    t0 = cyc;
  endtask

  // Advances n cycles, answers tx_ena with tx_done after done_delay, records outputs.
  task automatic observe(input int n);
    int rel;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      rel = cyc - t0;
      req_ack = 1'b0; req_nack = 1'b0; req_data = 1'b0;
      tx_done = (rel == tx_done_at);
      #1;
      if (write_enable) begin got_q.push_back(buffer_data); we_cyc_q.push_back(rel); end
      if (write_done) wd_cyc_q.push_back(rel);
      if (tx_ena) begin
        tx_cyc_q.push_back(rel);
        kind_q.push_back({send_data, tx_ack, tx_nack});
        if (done_delay > 0) tx_done_at = rel + done_delay;
      end
      if (sent) sent_cyc_q.push_back(rel);
      if (err_timeout) err_cyc_q.push_back(rel);
      if (prev_busy && !busy) busy_fall_q.push_back(rel);
      prev_busy = busy;
    end
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    observe(2);
    checks++;
    if ({fifo_rd, tx_ena, send_data, tx_ack, tx_nack, buffer_data, write_enable,
         write_done, busy, sent, err_timeout} !== 18'd0)
      $display("[TB] FAIL reset_outputs: got busy=%b we=%b tx_ena=%b, expected all 0", busy, write_enable, tx_ena);
    else passes++;
    n_rst = 1'b1;
    observe(2);
    checks++;
    if (busy !== 1'b0 || tx_ena !== 1'b0) $display("[TB] FAIL after_reset_idle: got busy=%b tx_ena=%b, expected 0 0", busy, tx_ena);
    else passes++;
  endtask

  task automatic test_ack();
    clear_obs();
    done_delay = 38;
    req_ack = 1'b1;
    observe(60);
    checks++;
    if (tx_cyc_q.size() != 1 || first_of(tx_cyc_q) != 2)
      $display("[TB] FAIL ack_tx_ena: got %0d pulses first at %0d, expected 1 at 2", tx_cyc_q.size(), first_of(tx_cyc_q));
    else passes++;
    checks++;
    if (kind_first(kind_q) != 3'b010) $display("[TB] FAIL ack_kind: got %0b expected 010", kind_first(kind_q));
    else passes++;
    checks++;
    if (sent_cyc_q.size() != 1 || first_of(sent_cyc_q) != 40)
      $display("[TB] FAIL ack_sent: got %0d pulses at %0d, expected 1 at 40", sent_cyc_q.size(), first_of(sent_cyc_q));
    else passes++;
    checks++;
    if (first_of(busy_fall_q) != 57) $display("[TB] FAIL ack_busy_drop: got cycle %0d expected 57", first_of(busy_fall_q));
    else passes++;
  endtask

  task automatic test_data_load();
    logic [7:0] pat [8] = '{8'hAA, 8'hCC, 8'hF0, 8'hF3, 8'hA3, 8'hAA, 8'h5C, 8'hFE};
    clear_obs();
    for (int i = 0; i < 8; i++) push_byte(pat[i], 1'b1);
    done_delay = 3;
    data_len = 7'd8; req_data = 1'b1;
    observe(35);
    checks++;
    if (got_q.size() != 8) $display("[TB] FAIL data_byte_count: got %0d expected 8", got_q.size());
    else passes++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) $display("[TB] FAIL data_byte: got %02h expected %02h", g, e);
      else passes++;
    end
    checks++;
    if (first_of(we_cyc_q) != 2 || we_cyc_q.size() != 8 || we_cyc_q[we_cyc_q.size()-1] != 9)
      $display("[TB] FAIL data_we_window: got first %0d count %0d, expected 2..9", first_of(we_cyc_q), we_cyc_q.size());
    else passes++;
    checks++;
    if (wd_cyc_q.size() != 1 || first_of(wd_cyc_q) != 10)
      $display("[TB] FAIL data_write_done: got %0d pulses at %0d, expected 1 at 10", wd_cyc_q.size(), first_of(wd_cyc_q));
    else passes++;
    checks++;
    if (first_of(tx_cyc_q) != 11 || kind_first(kind_q) != 3'b100)
      $display("[TB] FAIL data_tx_ena: got cycle %0d kind %0b, expected 11 kind 100", first_of(tx_cyc_q), kind_first(kind_q));
    else passes++;
  endtask

  task automatic test_back_to_back();
    clear_obs();
    push_byte(8'h11, 1'b1); push_byte(8'h22, 1'b1);
    done_delay = 3;
    data_len = 7'd2; req_ack = 1'b1; req_nack = 1'b1; req_data = 1'b1;
    observe(60);
    checks++;
    if (tx_cyc_q.size() != 2 || first_of(tx_cyc_q) != 2 || tx_cyc_q[tx_cyc_q.size()-1] != 26)
      $display("[TB] FAIL b2b_tx_count: got %0d pulses first at %0d, expected 2 at 2 and 26", tx_cyc_q.size(), first_of(tx_cyc_q));
    else passes++;
    checks++;
    if (kind_q.size() != 2 || kind_q[0] !== 3'b010 || kind_q[1] !== 3'b100)
      $display("[TB] FAIL b2b_kinds: got %0d kinds first %0b, expected ACK then DATA", kind_q.size(), kind_first(kind_q));
    else passes++;
    checks++;
    if (first_of(we_cyc_q) != 23 || we_cyc_q.size() != 2)
      $display("[TB] FAIL b2b_load_start: got first we %0d count %0d, expected 23 count 2", first_of(we_cyc_q), we_cyc_q.size());
    else passes++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) $display("[TB] FAIL b2b_byte: got %02h expected %02h", g, e);
      else passes++;
    end
  endtask

  task automatic test_fifo_stall();
    int exp_we [4] = '{2, 3, 24, 25};
    clear_obs();
    push_byte(8'h31, 1'b1); push_byte(8'h32, 1'b1);
    done_delay = 3;
    data_len = 7'd4; req_data = 1'b1;
    observe(23);
    push_byte(8'h33, 1'b1); push_byte(8'h34, 1'b1);
    observe(30);
    checks++;
    if (we_cyc_q.size() != 4) $display("[TB] FAIL stall_we_count: got %0d expected 4", we_cyc_q.size());
    else passes++;
    for (int i = 0; i < 4 && i < we_cyc_q.size(); i++) begin
      checks++;
      if (we_cyc_q[i] != exp_we[i]) $display("[TB] FAIL stall_we_cycle: got %0d expected %0d", we_cyc_q[i], exp_we[i]);
      else passes++;
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) $display("[TB] FAIL stall_byte: got %02h expected %02h", g, e);
      else passes++;
    end
    checks++;
    if (wd_cyc_q.size() != 1 || first_of(wd_cyc_q) != 26 || first_of(tx_cyc_q) != 27)
      $display("[TB] FAIL stall_done: got write_done %0d tx_ena %0d, expected 26 and 27", first_of(wd_cyc_q), first_of(tx_cyc_q));
    else passes++;
  endtask

  task automatic test_timeout();
    clear_obs();
    done_delay = 0;
    data_len = 7'd0; req_data = 1'b1;
    observe(12030);
    checks++;
    if (err_cyc_q.size() != 1 || first_of(err_cyc_q) != 12004)
      $display("[TB] FAIL timeout_pulse: got %0d pulses at %0d, expected 1 at 12004", err_cyc_q.size(), first_of(err_cyc_q));
    else passes++;
    checks++;
    if (sent_cyc_q.size() != 0 || first_of(busy_fall_q) != 12021)
      $display("[TB] FAIL timeout_gap: got sent %0d busy drop %0d, expected 0 and 12021", sent_cyc_q.size(), first_of(busy_fall_q));
    else passes++;
    clear_obs();
    done_delay = 3;
    req_nack = 1'b1;
    observe(30);
    checks++;
    if (first_of(tx_cyc_q) != 2 || kind_first(kind_q) != 3'b001 || first_of(sent_cyc_q) != 5)
      $display("[TB] FAIL timeout_recover_nak: got tx %0d kind %0b sent %0d, expected 2 001 5", first_of(tx_cyc_q), kind_first(kind_q), first_of(sent_cyc_q));
    else passes++;
  endtask

  task automatic test_zlp_clamp_reset();
    clear_obs();
    done_delay = 3;
    data_len = 7'd0; req_data = 1'b1;
    observe(30);
    checks++;
    if (we_cyc_q.size() != 0 || first_of(wd_cyc_q) != 2 || first_of(tx_cyc_q) != 3 || kind_first(kind_q) != 3'b100)
      $display("[TB] FAIL zlp: got we %0d done %0d tx %0d kind %0b, expected 0 2 3 100", we_cyc_q.size(), first_of(wd_cyc_q), first_of(tx_cyc_q), kind_first(kind_q));
    else passes++;

    clear_obs();
    for (int i = 0; i < 70; i++) push_byte(8'($urandom_range(0, 255)), i < 64);
    data_len = 7'd100; req_data = 1'b1;
    observe(90);
    checks++;
    if (we_cyc_q.size() != 64 || first_of(wd_cyc_q) != 66 || first_of(tx_cyc_q) != 67)
      $display("[TB] FAIL clamp: got we %0d done %0d tx %0d, expected 64 66 67", we_cyc_q.size(), first_of(wd_cyc_q), first_of(tx_cyc_q));
    else passes++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) $display("[TB] FAIL clamp_byte: got %02h expected %02h", g, e);
      else passes++;
    end

    clear_obs();
    for (int i = 0; i < 20; i++) push_byte(8'(i), 1'b0);
    data_len = 7'd20; req_data = 1'b1;
    observe(5);
    n_rst = 1'b0;
    #1;
    checks++;
    if ({fifo_rd, tx_ena, send_data, tx_ack, tx_nack, buffer_data, write_enable,
         write_done, busy, sent, err_timeout} !== 18'd0)
      $display("[TB] FAIL reset_mid_load: got busy=%b we=%b data=%02h, expected all 0", busy, write_enable, buffer_data);
    else passes++;
    observe(1);
    n_rst = 1'b1;
    clear_obs();
    observe(40);
    checks++;
    if (we_cyc_q.size() != 0 || wd_cyc_q.size() != 0 || tx_cyc_q.size() != 0 || busy !== 1'b0)
      $display("[TB] FAIL after_reset_quiet: got we %0d done %0d tx %0d busy %b, expected none", we_cyc_q.size(), wd_cyc_q.size(), tx_cyc_q.size(), busy);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_ack();
    test_data_load();
    test_back_to_back();
    test_fifo_stall();
    test_timeout();
    test_zlp_clamp_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
